// File: rtl/lr5_matrix_pkg.sv
// Shared definitions for the 8x8 key matrix scanner: FSM encoding,
// default timing constants and the key bit-index convention (8*col + row)
// that the display driver uses as well.
package lr5_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        FRAME = 2'd2
    } state_t;

    localparam int DEF_CLK_REF    = 48_000_000;
    localparam int DEF_CLK_CE     = 1_000_000;
    localparam int DEF_DEB_FRAMES = 3;

    localparam int N_COLS = 8;
    localparam int N_ROWS = 8;
    localparam int N_KEYS = N_COLS * N_ROWS;
    localparam int KEY_W  = 6;

    // Bit position of a key in the 64-bit map: column in the upper three bits.
    function automatic logic [KEY_W-1:0] key_index(input logic [2:0] col, input logic [2:0] row);
        return {col, row};
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [KEY_W-1:0] lowest_set(input logic [N_KEYS-1:0] v);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = KEY_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/lr5_sync2.sv
// Two-flop synchronizer for the asynchronous row sense lines.
module lr5_sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/lr5_matrix_keyscan.sv
// 8x8 key matrix scanner: drives one column at a time, samples the rows after
// a settle time, debounces whole frames and publishes the committed key map
// together with the lowest changed key and its new level.
module lr5_matrix_keyscan
    import lr5_matrix_pkg::*;
#(
    parameter int CLK_REF    = DEF_CLK_REF,
    parameter int CLK_CE     = DEF_CLK_CE,
    parameter int DEB_FRAMES = DEF_DEB_FRAMES
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic [7:0]  STR_I,
    output logic [7:0]  CLM,
    output logic [63:0] DAT_O,
    output logic        CHG,
    output logic [5:0]  KEY_CODE,
    output logic        PRESS,
    output state_t      state_dbg
);

    // Never settle for fewer than 3 cycles: the synchronizer alone eats two.
    localparam int SETTLE_RAW = CLK_REF / CLK_CE;
    localparam int SETTLE_CYC = (SETTLE_RAW < 3) ? 3 : SETTLE_RAW;
    localparam int CNT_W      = $clog2(SETTLE_CYC);
    localparam int DEB_W      = $clog2(DEB_FRAMES + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_MAX     = DEB_W'(DEB_FRAMES);

    state_t            state, state_n;
    logic [2:0]        col, col_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              sample;
    logic [7:0]        clm_n;

    logic [7:0]        rows_s;
    logic [63:0]       raw, prev_raw;
    logic [DEB_W-1:0]  stable_cnt, stable_upd;
    logic              frame_same;
    logic [63:0]       diff;
    logic              commit;
    logic [5:0]        code_n;

    lr5_sync2 #(.W(8)) u_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (STR_I),
        .q     (rows_s)
    );

    assign state_dbg = state;

    // Next-state logic: column walk, settle counter, and the registered column drive.
    always_comb begin
        state_n = state;
        col_n   = col;
        cnt_n   = cnt;
        sample  = 1'b0;
        case (state)
            IDLE: begin
                if (CE) begin
                    state_n = DRIVE;
                    col_n   = 3'd0;
                    cnt_n   = '0;
                end
            end
            DRIVE: begin
                if (cnt == SETTLE_LAST) begin
                    sample = 1'b1;
                    cnt_n  = '0;
                    if (col == 3'd7) state_n = FRAME;
                    else             col_n   = col + 3'd1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FRAME: begin
                col_n   = 3'd0;
                cnt_n   = '0;
                state_n = CE ? DRIVE : IDLE;
            end
            default: begin
                state_n = IDLE;
                col_n   = 3'd0;
                cnt_n   = '0;
            end
        endcase
        clm_n = (state_n == DRIVE) ? (8'b1 << col_n) : 8'h00;
    end

    // Debounce decision for the frame that just completed.
    always_comb begin
        frame_same = (raw == prev_raw);
        stable_upd = DEB_W'(1);
        if (frame_same) stable_upd = (stable_cnt == DEB_MAX) ? stable_cnt : stable_cnt + 1'b1;
        diff   = raw ^ DAT_O;
        commit = (state == FRAME) && (stable_upd == DEB_MAX) && (diff != '0);
        code_n = lowest_set(diff);
    end

    // FSM registers and the registered column drive.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            col   <= 3'd0;
            cnt   <= '0;
            CLM   <= 8'h00;
        end else begin
            state <= state_n;
            col   <= col_n;
            cnt   <= cnt_n;
            CLM   <= clm_n;
        end
    end

    // Frame capture, stability tracking and commit of the debounced map.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            raw        <= '0;
            prev_raw   <= '0;
            stable_cnt <= '0;
            DAT_O      <= '0;
            CHG        <= 1'b0;
            KEY_CODE   <= '0;
            PRESS      <= 1'b0;
        end else begin
            CHG <= commit;
            if (sample) raw[key_index(col, 3'd0) +: 8] <= rows_s;
            if (state == FRAME) begin
                stable_cnt <= stable_upd;
                if (!frame_same) prev_raw <= raw;
            end
            if (commit) begin
                DAT_O    <= raw;
                KEY_CODE <= code_n;
                PRESS    <= raw[code_n];
            end
        end
    end

endmodule

// File: tb/tb_lr5_matrix_keyscan.sv
// Bench for the key matrix scanner: a behavioural key matrix feeds the rows
// from the driven column, expected commits are queued when keys change and
// compared whenever the scanner pulses CHG.
module tb_lr5_matrix_keyscan;
    import lr5_matrix_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CE  = 1'b0;
    logic [7:0]  STR_I;
    logic [7:0]  CLM;
    logic [63:0] DAT_O;
    logic        CHG;
    logic [5:0]  KEY_CODE;
    logic        PRESS;
    state_t      state_dbg;

    logic [63:0] keys = '0;
    logic [63:0] dat_model = '0;
    logic [70:0] exp_q[$];
    logic [70:0] mon_e;
    logic        chg_prev = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          chg_count = 0;

    lr5_matrix_keyscan dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .STR_I     (STR_I),
        .CLM       (CLM),
        .DAT_O     (DAT_O),
        .CHG       (CHG),
        .KEY_CODE  (KEY_CODE),
        .PRESS     (PRESS),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    always #5 CLK = ~CLK;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // Key matrix: a closed key connects its column drive to its row line.
    always_comb begin
        STR_I = '0;
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 8; r++)
                if (CLM[c] && keys[8*c+r]) STR_I[r] = 1'b1;
    end

    task automatic check(input string tag, input logic [70:0] got, input logic [70:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: every CHG must be a single cycle and match the queue head.
    always @(negedge CLK) begin
        if (RST && CHG) begin
            check("chg_pulse_width", 71'(chg_prev), 71'd0);
            if (exp_q.size() == 0) begin
                check("chg_unexpected_pending", 71'(exp_q.size()), 71'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit", {DAT_O, KEY_CODE, PRESS}, mon_e);
            end
            chg_count++;
        end
        chg_prev = CHG;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_clm(input logic [7:0] v, input int budget, input string tag);
        int k;
        k = 0;
        while (CLM !== v && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check(tag, 71'(CLM), 71'(v));
    endtask

    task automatic wait_frame_end();
        wait_clm(8'h80, 800, "reach_col7");
        wait_clm(8'h00, 60, "reach_frame");
    endtask

    // Expected commit: whole new map, lowest changed index, new level of that bit.
    task automatic push_expect(input logic [63:0] new_k, input logic [63:0] old);
        logic [63:0] d;
        int          code;
        bit          found;
        d     = new_k ^ old;
        code  = 0;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (d[i] && !found) begin
                code  = i;
                found = 1'b1;
            end
        end
        exp_q.push_back({new_k, 6'(code), new_k[code]});
    endtask

    // Commit must land exactly at the end of the third frame, not earlier.
    task automatic verify_three_frames(input string tag, input int base, input int inc);
        wait_frame_end();
        wait_frame_end();
        cycles(2);
        check({tag, "_early"}, 71'(chg_count), 71'(base));
        wait_frame_end();
        cycles(2);
        check({tag, "_count"}, 71'(chg_count), 71'(base + inc));
        check({tag, "_dat"}, 71'(DAT_O), 71'(dat_model));
    endtask

    task automatic apply_and_verify(input logic [63:0] k, input string tag);
        int base;
        int inc;
        base = chg_count;
        inc  = (k != dat_model) ? 1 : 0;
        keys = k;
        if (inc != 0) push_expect(k, dat_model);
        dat_model = k;
        verify_three_frames(tag, base, inc);
    endtask

    initial begin
        int base;
        int b;
        logic [63:0] k;

        // Reset state.
        cycles(3);
        check("rst_clm", 71'(CLM), 71'd0);
        check("rst_dat", 71'(DAT_O), 71'd0);
        check("rst_chg", 71'(CHG), 71'd0);
        check("rst_code", 71'(KEY_CODE), 71'd0);
        check("rst_press", 71'(PRESS), 71'd0);
        check("rst_state", 71'(state_dbg), 71'(IDLE));

        RST = 1'b1;
        CE  = 1'b1;
        wait_clm(8'h01, 2, "start_col0");

        // Scan order: each column 48 cycles, then one idle-drive frame cycle.
        for (int i = 0; i < 385; i++) begin
            check("scan_clm", 71'(CLM), 71'((i < 384) ? (8'h01 << (i / 48)) : 8'h00));
            @(negedge CLK);
        end
        check("scan_period", 71'(CLM), 71'h01);
        wait_frame_end();
        wait_frame_end();
        check("scan_no_chg", 71'(chg_count), 71'd0);

        // Single press and release of column 2 row 5.
        apply_and_verify(64'd1 << 21, "press21");
        check("press21_code", 71'(KEY_CODE), 71'd21);
        check("press21_press", 71'(PRESS), 71'd1);
        apply_and_verify(64'd0, "release21");
        check("release21_press", 71'(PRESS), 71'd0);

        // Bounce: toggle for five frames, then hold closed.
        b = $urandom_range(0, 63);
        base = chg_count;
        for (int t = 0; t < 5; t++) begin
            keys = (t % 2 == 0) ? (64'd1 << b) : 64'd0;
            wait_frame_end();
        end
        check("bounce_quiet", 71'(chg_count), 71'(base));
        push_expect(64'd1 << b, dat_model);
        dat_model = 64'd1 << b;
        wait_frame_end();
        cycles(2);
        check("bounce_early", 71'(chg_count), 71'(base));
        wait_frame_end();
        cycles(2);
        check("bounce_once", 71'(chg_count), 71'(base + 1));
        apply_and_verify(64'd0, "bounce_release");

        // Multi-key in one frame: one commit, lowest index reported.
        apply_and_verify(64'h8000_0000_0000_0001, "multi");
        check("multi_code", 71'(KEY_CODE), 71'd0);
        apply_and_verify(64'd0, "multi_release");

        // CE drop in column 4 of the committing frame: frame finishes, then idle.
        k = 64'd1 << $urandom_range(0, 63);
        base = chg_count;
        keys = k;
        push_expect(k, dat_model);
        dat_model = k;
        wait_frame_end();
        wait_frame_end();
        cycles(2);
        wait_clm(8'h10, 300, "ce_col4");
        CE = 1'b0;
        wait_clm(8'h20, 60, "ce_col5");
        wait_clm(8'h40, 60, "ce_col6");
        wait_clm(8'h80, 60, "ce_col7");
        wait_clm(8'h00, 60, "ce_frame");
        cycles(2);
        check("ce_commit", 71'(chg_count), 71'(base + 1));
        check("ce_state_idle", 71'(state_dbg), 71'(IDLE));
        cycles(100);
        check("ce_idle_clm", 71'(CLM), 71'd0);
        check("ce_idle_dat", 71'(DAT_O), 71'(k));
        CE = 1'b1;
        wait_clm(8'h01, 2, "ce_restart");

        // Asynchronous reset in the middle of column 2.
        cycles(100);
        #3;
        RST = 1'b0;
        #1;
        check("arst_clm", 71'(CLM), 71'd0);
        check("arst_dat", 71'(DAT_O), 71'd0);
        check("arst_chg", 71'(CHG), 71'd0);
        check("arst_code", 71'(KEY_CODE), 71'd0);
        check("arst_press", 71'(PRESS), 71'd0);
        check("arst_state", 71'(state_dbg), 71'(IDLE));
        @(negedge CLK);
        cycles(3);
        dat_model = '0;
        base = chg_count;
        RST = 1'b1;
        wait_clm(8'h01, 2, "arst_restart");
        push_expect(k, 64'd0);
        dat_model = k;
        verify_three_frames("arst_recommit", base, 1);

        apply_and_verify(64'd0, "final_release");
        check("queue_drained", 71'(exp_q.size()), 71'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
